// File: rtl/cic_pkg.sv
// Shared types and helpers for the programmable CIC decimator.
package cic_pkg;

  localparam int unsigned ORDER_MIN = 1;
  localparam int unsigned ORDER_MAX = 5;
  localparam int unsigned DEC_W     = 4;

  typedef logic [DEC_W-1:0] dec_log2_t;

  function automatic int unsigned cic_width(input int unsigned order,
                                            input int unsigned dec_log2_max);
    return order * dec_log2_max + 1;
  endfunction

endpackage

// File: rtl/cic_comb_chain.sv
// Comb (differentiator) chain with output scaling to OUT_W bits.
// Optional round-half-up before truncation when CIC_ROUND_EN is defined.
module cic_comb_chain
  import cic_pkg::*;
#(
  parameter int unsigned ORDER = 3,
  parameter int unsigned W     = 25,
  parameter int unsigned OUT_W = 14
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clr,
  input  logic             step,
  input  logic [DEC_W-1:0] dec_active,
  input  logic [W-1:0]     acc_in,
  output logic [OUT_W-1:0] q
);

  localparam int unsigned SH_W = $clog2(W + OUT_W + 1);

  logic [W-1:0]      dly [1:ORDER];
  logic [W-1:0]      d   [0:ORDER];
  logic [SH_W-1:0]   s_msb;
  logic [W:0]        d_rnd;

  always_comb begin
    d[0] = acc_in;
    for (int unsigned j = 1; j <= ORDER; j++) begin
      d[j] = d[j-1] - dly[j];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned j = 1; j <= ORDER; j++) dly[j] <= '0;
    end else if (clr) begin
      for (int unsigned j = 1; j <= ORDER; j++) dly[j] <= '0;
    end else if (step) begin
      for (int unsigned j = 1; j <= ORDER; j++) dly[j] <= d[j-1];
    end
  end

  // Full scale R^ORDER sits at bit s_msb = ORDER*k.
  assign s_msb = SH_W'(ORDER) * SH_W'(dec_active);

`ifdef CIC_ROUND_EN
  always_comb begin
    d_rnd = {1'b0, d[ORDER]};
    if (s_msb >= SH_W'(OUT_W)) begin
      d_rnd = d_rnd + ((W+1)'(1) << (s_msb - SH_W'(OUT_W)));
    end
  end
`else
  assign d_rnd = {1'b0, d[ORDER]};
`endif

  // Placing d above OUT_W zero bits and shifting right by s_msb+1 covers
  // both the truncating and the zero-padding cases in one expression.
  always_comb begin
    q = OUT_W'({d_rnd, {OUT_W{1'b0}}} >> (s_msb + SH_W'(1)));
  end

endmodule

// File: rtl/cic_decim_prog.sv
// N-th order CIC decimator for a 1-bit sigma-delta stream, run-time ratio 2^k.
// Define CIC_ROUND_EN for round-half-up output scaling (see cic_comb_chain).
module cic_decim_prog
  import cic_pkg::*;
#(
  parameter int unsigned ORDER        = 3,
  parameter int unsigned DEC_LOG2_MIN = 3,
  parameter int unsigned DEC_LOG2_MAX = 8,
  parameter int unsigned OUT_W        = 14
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic             in,
  input  logic [DEC_W-1:0] dec_log2,
  output logic [OUT_W-1:0] out,
  output logic             out_valid,
  output logic [DEC_W-1:0] dec_active
);

  localparam int unsigned W      = cic_width(ORDER, DEC_LOG2_MAX);
  localparam int unsigned WARM_W = $clog2(ORDER_MAX + 1);

  logic [W-1:0]            acc [1:ORDER];
  logic [DEC_LOG2_MAX-1:0] cnt;
  logic [DEC_LOG2_MAX:0]   lim;
  logic                    frame_last;
  logic                    frame_pend;
  logic [WARM_W-1:0]       warm;
  logic                    warm_done;
  dec_log2_t               k_req;
  logic                    ratio_chg;
  logic [OUT_W-1:0]        q;

  always_comb begin
    k_req = dec_log2;
    if (dec_log2 < dec_log2_t'(DEC_LOG2_MIN)) k_req = dec_log2_t'(DEC_LOG2_MIN);
    else if (dec_log2 > dec_log2_t'(DEC_LOG2_MAX)) k_req = dec_log2_t'(DEC_LOG2_MAX);
  end

  assign ratio_chg  = (k_req != dec_active);
  assign lim        = ((DEC_LOG2_MAX+1)'(1) << dec_active) - (DEC_LOG2_MAX+1)'(1);
  assign frame_last = ({1'b0, cnt} == lim);
  assign warm_done  = (warm == WARM_W'(ORDER));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 1; i <= ORDER; i++) acc[i] <= '0;
      cnt        <= '0;
      frame_pend <= 1'b0;
      warm       <= '0;
      out        <= '0;
      out_valid  <= 1'b0;
      dec_active <= dec_log2_t'(DEC_LOG2_MAX);
    end else if (ratio_chg) begin
      // Ratio change outranks a frame completing on the same edge.
      for (int unsigned i = 1; i <= ORDER; i++) acc[i] <= '0;
      cnt        <= '0;
      frame_pend <= 1'b0;
      warm       <= '0;
      out_valid  <= 1'b0;
      dec_active <= k_req;
    end else begin
      out_valid  <= 1'b0;
      frame_pend <= en & frame_last;
      if (en) begin
        acc[1] <= acc[1] + {{(W-1){1'b0}}, in};
        for (int unsigned i = 2; i <= ORDER; i++) acc[i] <= acc[i] + acc[i-1];
        cnt <= frame_last ? '0 : cnt + DEC_LOG2_MAX'(1);
      end
      if (frame_pend) begin
        if (warm_done) begin
          out       <= q;
          out_valid <= 1'b1;
        end else begin
          warm <= warm + WARM_W'(1);
        end
      end
    end
  end

  cic_comb_chain #(
    .ORDER (ORDER),
    .W     (W),
    .OUT_W (OUT_W)
  ) u_comb (
    .clk        (clk),
    .reset_n    (reset_n),
    .clr        (ratio_chg),
    .step       (frame_pend),
    .dec_active (dec_active),
    .acc_in     (acc[ORDER]),
    .q          (q)
  );

endmodule

// File: tb/tb_cic_decim_prog.sv
// Scoreboard bench for cic_decim_prog: directed phases push expected strobes,
// a negedge monitor pops and compares value and arrival cycle.
module tb_cic_decim_prog;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        en;
  logic        in;
  logic [3:0]  dec_log2;
  logic [13:0] out;
  logic        out_valid;
  logic [3:0]  dec_active;

  cic_decim_prog #(
    .ORDER        (3),
    .DEC_LOG2_MIN (3),
    .DEC_LOG2_MAX (8),
    .OUT_W        (14)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .en         (en),
    .in         (in),
    .dec_log2   (dec_log2),
    .out        (out),
    .out_valid  (out_valid),
    .dec_active (dec_active)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [13:0] val;
    int          at;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int base   = 0;
  int offset = 0;
  int sidx   = 0;
  int pat    = 0;
  int tog    = 0;

  initial forever begin
    @(posedge clk);
    cyc <= cyc + 1;
  end

  initial forever begin
    exp_t e;
    @(negedge clk);
    if (reset_n === 1'b1 && out_valid === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL strobe: unexpected out_valid at rel cycle %0d out=%0d, required no strobe",
                 cyc - base, out);
      end else begin
        e = sb.pop_front();
        if (out !== e.val || cyc != e.at) begin
          errors++;
          $display("FAIL strobe: rel cycle %0d out=%0d, required rel cycle %0d out=%0d",
                   cyc - base, out, e.at - base, e.val);
        end
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  // Drives en/in for the upcoming edge; r is the 1-based edge index after
  // the (optional) ratio-change edge.
  task automatic drive();
    int r;
    r = cyc - base + 1 - offset;
    if (r < 1) begin
      en = 1'b1;
      in = 1'b0;
    end else begin
      en = (tog == 0) || (r % 2 == 1);
      if (en) begin
        case (pat)
          0:       in = 1'b1;
          1:       in = 1'b0;
          2:       in = (sidx % 2 == 0);
          default: in = (sidx % 4 == 0);
        endcase
        sidx++;
      end else begin
        in = 1'b0;
      end
    end
  endtask

  task automatic do_reset(input int k);
    int kk;
    @(negedge clk);
    reset_n  = 1'b0;
    en       = 1'b0;
    in       = 1'b0;
    dec_log2 = 4'(k);
    sb.delete();
    repeat (2) @(negedge clk);
    check("rst_out", int'(out), 0);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_dec_active", int'(dec_active), 8);
    kk = (k < 3) ? 3 : ((k > 8) ? 8 : k);
    @(negedge clk);
    reset_n = 1'b1;
    base    = cyc;
    offset  = (kk != 8) ? 1 : 0;
    sidx    = 0;
    drive();
  endtask

  task automatic push_frames(input int r, input int stp, input int f0, input int n,
                             input logic [13:0] val);
    exp_t e;
    for (int f = f0; f < f0 + n; f++) begin
      e.val = val;
      e.at  = base + offset + stp * (f * r - 1) + 2;
      sb.push_back(e);
    end
  endtask

  task automatic run_wait(input int limit);
    while (sb.size() > 0 && (cyc - base) < limit) begin
      @(negedge clk);
      drive();
    end
    if (sb.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL timeout: %0d strobes missing by rel cycle %0d, required 0", sb.size(), limit);
      sb.delete();
    end
  endtask

  task automatic phase(input int k, input int p, input int t, input int n,
                       input logic [13:0] val);
    int r;
    int stp;
    pat = p;
    tog = t;
    r   = 1 << k;
    stp = (t != 0) ? 2 : 1;
    do_reset(k);
    push_frames(r, stp, 4, n, val);
    run_wait(offset + stp * ((3 + n) * r) + 40);
  endtask

  initial begin
    reset_n  = 1'b0;
    en       = 1'b0;
    in       = 1'b0;
    dec_log2 = 4'd8;

    phase(8, 0, 0, 3, 14'd8192);   // all ones, first strobe at 1025
    phase(8, 1, 0, 2, 14'd0);      // all zeros
    phase(8, 2, 0, 2, 14'd4096);   // alternating 1,0
    phase(3, 0, 0, 3, 14'd8192);   // zero-padded scaling
    phase(5, 0, 1, 2, 14'd8192);   // en every other cycle
    phase(8, 3, 0, 2, 14'd2048);   // 1-in-4, exact with or without rounding

    // Ratio change 8 -> 4 landing on the edge that would strobe frame 5.
    pat = 0;
    tog = 0;
    do_reset(8);
    push_frames(256, 1, 4, 1, 14'd8192);
    while ((cyc - base) < 1280) begin
      @(negedge clk);
      if ((cyc - base) == 1280) begin
        dec_log2 = 4'd4;
        offset   = 1281;
        sidx     = 0;
      end
      drive();
    end
    check("chg_pre_queue", sb.size(), 0);
    push_frames(16, 1, 4, 2, 14'd8192);
    @(negedge clk);
    drive();
    check("chg_dec_active", int'(dec_active), 4);
    check("chg_out_hold", int'(out), 8192);
    check("chg_no_valid", int'(out_valid), 0);
    repeat (20) begin
      @(negedge clk);
      drive();
    end
    check("chg_out_hold_mid", int'(out), 8192);
    run_wait(1281 + 65 + 16 + 40);

    // Clamping of out-of-range requests.
    pat = 1;
    do_reset(15);
    repeat (3) begin
      @(negedge clk);
      drive();
    end
    check("clamp_hi", int'(dec_active), 8);
    dec_log2 = 4'd0;
    repeat (2) begin
      @(negedge clk);
      drive();
    end
    check("clamp_lo", int'(dec_active), 3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
